// File: rtl/td4_chan_mux_pkg.sv
// Shared types and helpers for the TD4 channel selector.
// Holds the controller state encoding, the mode encodings and a select-width helper.
package td4_mux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_e;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Width needed to index n items, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/td4_chan_mux_if.sv
// Data/control bundle between a TD4 channel source/sink and td4_chan_mux.
// The master drives channel data and controls; the slave (the selector) drives the outputs.
interface td4_chan_mux_if #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4
);
  import td4_mux_pkg::*;

  localparam int SEL_W = clog2_min1(CHANNELS);

  logic [CHANNELS*WIDTH-1:0] data_in;
  logic [SEL_W-1:0]          sel_in;
  logic                      mode;
  logic                      load_sel;
  logic                      hold;
  logic [WIDTH-1:0]          out;
  logic [SEL_W-1:0]          out_sel;
  logic                      out_valid;
  logic                      wrap;

  modport master (
    output data_in, sel_in, mode, load_sel, hold,
    input  out, out_sel, out_valid, wrap
  );

  modport slave (
    input  data_in, sel_in, mode, load_sel, hold,
    output out, out_sel, out_valid, wrap
  );

endinterface

// File: rtl/td4_chan_mux_dwell_counter.sv
// Dwell timer for scan mode: counts 0..DWELL-1 while enabled and raises tick
// on the terminal count, in the same cycle the count wraps back to zero.
module td4_dwell_counter
  import td4_mux_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);

  localparam int CW = clog2_min1(DWELL);
  localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && !clear && (cnt_q == LAST);

  // NOTE: every combinationally assigned signal gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/td4_chan_mux.sv
// Registered N-channel selector with direct select and auto-scan modes.
// Outputs carry data, source channel, an in-range flag and a wrap pulse.
module td4_chan_mux
  import td4_mux_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 1
) (
  input logic           clk,
  input logic           reset,
  td4_chan_mux_if.slave bus
);

  localparam int SEL_W = clog2_min1(CHANNELS);
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             wrap_pend_q, wrap_pend_d;

  logic [SEL_W-1:0] idx;
  logic [WIDTH-1:0] chan_data;
  logic             chan_ok;
  logic             run_direct, run_scan, dwell_tick;

  assign run_direct = !bus.hold && (bus.mode == MODE_DIRECT);
  assign run_scan   = !bus.hold && (bus.mode == MODE_SCAN);

  // Direct mode and a scan reload both take the channel from sel_in.
  assign idx = ((bus.mode == MODE_DIRECT) || bus.load_sel) ? bus.sel_in : ptr_q;

  td4_dwell_counter #(.DWELL(DWELL)) u_dwell (
    .clk   (clk),
    .reset (reset),
    .en    (run_scan && !bus.load_sel),
    .clear (run_direct || (run_scan && bus.load_sel)),
    .tick  (dwell_tick)
  );

  // Indices past the last channel yield zero data and chan_ok low.
  always_comb begin
    chan_data = '0;
    chan_ok   = 1'b0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx == SEL_W'(k)) begin
        chan_data = bus.data_in[k*WIDTH +: WIDTH];
        chan_ok   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    wrap_pend_d = wrap_pend_q;
    wrap_d      = 1'b0;
    out_d       = out_q;
    out_sel_d   = out_sel_q;
    valid_d     = valid_q;

    if (!bus.hold) begin
      state_d     = (bus.mode == MODE_SCAN) ? SCAN : DIRECT;
      out_d       = chan_data;
      out_sel_d   = idx;
      valid_d     = chan_ok;
      wrap_pend_d = 1'b0;
      if (run_direct || bus.load_sel) begin
        ptr_d = bus.sel_in;
      end else begin
        // The wrap pulse accompanies the first output taken from channel 0.
        wrap_d = wrap_pend_q;
        if (dwell_tick) begin
          if (ptr_q >= LAST_CH) begin
            ptr_d       = '0;
            wrap_pend_d = 1'b1;
          end else begin
            ptr_d = ptr_q + SEL_W'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wrap_pend_q <= 1'b0;
      wrap_q      <= 1'b0;
      out_q       <= '0;
      out_sel_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wrap_pend_q <= wrap_pend_d;
      wrap_q      <= wrap_d;
      out_q       <= out_d;
      out_sel_q   <= out_sel_d;
      valid_q     <= valid_d;
    end
  end

  assign bus.out       = out_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.out_valid = valid_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_td4_chan_mux.sv
// Self-checking bench for td4_chan_mux: three configurations driven by directed
// vectors, a per-cycle compare against a behavioural model, plus literal spot checks.
module tb_td4_chan_mux;

  logic clk;
  logic rst0, rst1, rst2;

  td4_chan_mux_if #(.WIDTH(4), .CHANNELS(4)) bus0 ();
  td4_chan_mux_if #(.WIDTH(4), .CHANNELS(4)) bus1 ();
  td4_chan_mux_if #(.WIDTH(4), .CHANNELS(3)) bus2 ();

  td4_chan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(1)) u0 (.clk(clk), .reset(rst0), .bus(bus0));
  td4_chan_mux #(.WIDTH(4), .CHANNELS(4), .DWELL(3)) u1 (.clk(clk), .reset(rst1), .bus(bus1));
  td4_chan_mux #(.WIDTH(4), .CHANNELS(3), .DWELL(1)) u2 (.clk(clk), .reset(rst2), .bus(bus2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: what the outputs must be after each edge, from the selector's rules.
  // cnt = cycles the current channel has been shown in scan mode.
  typedef struct {
    int ptr;
    int cnt;
    int wrapped;
    int out;
    int osel;
    int valid;
    int wrap;
  } mstate_t;

  function automatic mstate_t mstep(input mstate_t s, input int c, input int d,
                                    input logic [15:0] data, input int sel,
                                    input bit mode, input bit load, input bit hold,
                                    input bit rst);
    mstate_t n;
    int idx;
    n = s;
    if (rst) begin
      n = '{default: 0};
      return n;
    end
    if (hold) begin
      n.wrap = 0;
      return n;
    end
    n.wrap = 0;
    if (!mode || load) begin
      idx       = sel;
      n.ptr     = sel;
      n.cnt     = 0;
      n.wrapped = 0;
    end else begin
      idx       = s.ptr;
      n.wrap    = s.wrapped;
      n.wrapped = 0;
      n.cnt     = s.cnt + 1;
      if (n.cnt == d) begin
        n.cnt = 0;
        if (s.ptr + 1 >= c) begin
          n.ptr     = 0;
          n.wrapped = 1;
        end else begin
          n.ptr = s.ptr + 1;
        end
      end
    end
    n.osel = idx;
    if (idx < c) begin
      n.out   = int'((data >> (4 * idx)) & 16'hF);
      n.valid = 1;
    end else begin
      n.out   = 0;
      n.valid = 0;
    end
    return n;
  endfunction

  mstate_t m0, m1, m2;

  initial begin
    m0 = '{default: 0};
    m1 = '{default: 0};
    m2 = '{default: 0};
  end

  always @(posedge clk) begin
    m0 = mstep(m0, 4, 1, bus0.data_in, int'(bus0.sel_in), bus0.mode, bus0.load_sel, bus0.hold, rst0);
    m1 = mstep(m1, 4, 3, bus1.data_in, int'(bus1.sel_in), bus1.mode, bus1.load_sel, bus1.hold, rst1);
    m2 = mstep(m2, 3, 1, {4'h0, bus2.data_in}, int'(bus2.sel_in), bus2.mode, bus2.load_sel, bus2.hold, rst2);
  end

  task automatic cmp(input string tag, input mstate_t m, input logic [3:0] o,
                     input logic [1:0] os, input logic v, input logic w);
    check({tag, ".out"},       32'(o),  32'(m.out));
    check({tag, ".out_sel"},   32'(os), 32'(m.osel));
    check({tag, ".out_valid"}, 32'(v),  32'(m.valid));
    check({tag, ".wrap"},      32'(w),  32'(m.wrap));
  endtask

  always @(negedge clk) begin
    cmp("u0", m0, bus0.out, bus0.out_sel, bus0.out_valid, bus0.wrap);
    cmp("u1", m1, bus1.out, bus1.out_sel, bus1.out_valid, bus1.wrap);
    cmp("u2", m2, bus2.out, bus2.out_sel, bus2.out_valid, bus2.wrap);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  int scan_out[6]  = '{10, 11, 12, 13, 10, 11};
  int scan_wrap[6] = '{0, 0, 0, 0, 1, 0};
  int dw_out[18]   = '{10, 10, 10, 11, 11, 11, 11, 11, 11, 11, 11, 12, 12, 12, 13, 13, 13, 10};

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    bus0.data_in = 16'hDCBA; bus0.sel_in = 2'd0; bus0.mode = 1'b0; bus0.load_sel = 1'b0; bus0.hold = 1'b0;
    bus1.data_in = 16'hDCBA; bus1.sel_in = 2'd0; bus1.mode = 1'b1; bus1.load_sel = 1'b0; bus1.hold = 1'b0;
    bus2.data_in = 12'hCBA;  bus2.sel_in = 2'd0; bus2.mode = 1'b0; bus2.load_sel = 1'b0; bus2.hold = 1'b0;
    tick();
    tick();
    check("reset.out",       32'(bus0.out), 32'd0);
    check("reset.out_sel",   32'(bus0.out_sel), 32'd0);
    check("reset.out_valid", 32'(bus0.out_valid), 32'd0);
    check("reset.wrap",      32'(bus0.wrap), 32'd0);

    // Direct select on u0
    rst0 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus0.sel_in = 2'(i);
      tick();
      check("direct.out",       32'(bus0.out), 32'(10 + i));
      check("direct.out_sel",   32'(bus0.out_sel), 32'(i));
      check("direct.out_valid", 32'(bus0.out_valid), 32'd1);
    end
    bus0.data_in = 16'h2345;
    bus0.sel_in  = 2'd0;
    tick();
    check("direct.newdata", 32'(bus0.out), 32'd5);

    // Scan with DWELL=1 on u0
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    bus0.mode    = 1'b1;
    bus0.data_in = 16'hDCBA;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("scan1.out",  32'(bus0.out), 32'(scan_out[i]));
      check("scan1.wrap", 32'(bus0.wrap), 32'(scan_wrap[i]));
    end

    // load_sel jump on u0
    rst0 = 1'b1;
    tick();
    rst0 = 1'b0;
    tick();
    check("load.pre", 32'(bus0.out), 32'd10);
    bus0.load_sel = 1'b1;
    bus0.sel_in   = 2'd3;
    tick();
    check("load.out",  32'(bus0.out), 32'd13);
    check("load.wrap", 32'(bus0.wrap), 32'd0);
    bus0.load_sel = 1'b0;
    tick();
    check("load.dwell", 32'(bus0.out), 32'd13);
    tick();
    check("load.adv.out",  32'(bus0.out), 32'd10);
    check("load.adv.wrap", 32'(bus0.wrap), 32'd1);

    // Scan with DWELL=3 and a hold in the second cycle of B on u1
    rst1 = 1'b0;
    for (int i = 0; i < 18; i++) begin
      bus1.hold = (i >= 5 && i < 10);
      tick();
      check("dwell3.out",  32'(bus1.out), 32'(dw_out[i]));
      check("dwell3.wrap", 32'(bus1.wrap), (i == 17) ? 32'd1 : 32'd0);
    end

    // Reset with hold mid-scan (ptr=2, count=1) on u1
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    check("midscan.out", 32'(bus1.out), 32'd12);
    rst1 = 1'b1;
    bus1.hold = 1'b1;
    tick();
    check("rsthold.out",       32'(bus1.out), 32'd0);
    check("rsthold.out_sel",   32'(bus1.out_sel), 32'd0);
    check("rsthold.out_valid", 32'(bus1.out_valid), 32'd0);
    check("rsthold.wrap",      32'(bus1.wrap), 32'd0);
    rst1 = 1'b0;
    bus1.hold = 1'b0;
    tick();
    check("postrst.out",     32'(bus1.out), 32'd10);
    check("postrst.out_sel", 32'(bus1.out_sel), 32'd0);

    // Three channels: out-of-range select, direct-to-scan handoff, reload past the end
    rst2 = 1'b0;
    bus2.sel_in = 2'd3;
    tick();
    check("oor.out",       32'(bus2.out), 32'd0);
    check("oor.out_valid", 32'(bus2.out_valid), 32'd0);
    check("oor.out_sel",   32'(bus2.out_sel), 32'd3);
    bus2.sel_in = 2'd2;
    tick();
    check("c3.out",       32'(bus2.out), 32'hC);
    check("c3.out_valid", 32'(bus2.out_valid), 32'd1);
    bus2.sel_in = 2'd1;
    tick();
    bus2.mode = 1'b1;
    tick();
    check("handoff.out", 32'(bus2.out), 32'hB);
    tick();
    check("handoff.next", 32'(bus2.out), 32'hC);
    tick();
    check("c3wrap.out",  32'(bus2.out), 32'hA);
    check("c3wrap.wrap", 32'(bus2.wrap), 32'd1);
    bus2.load_sel = 1'b1;
    bus2.sel_in   = 2'd3;
    tick();
    check("oorload.out_valid", 32'(bus2.out_valid), 32'd0);
    check("oorload.out_sel",   32'(bus2.out_sel), 32'd3);
    bus2.load_sel = 1'b0;
    tick();
    tick();
    check("oorload.adv.out",  32'(bus2.out), 32'hA);
    check("oorload.adv.wrap", 32'(bus2.wrap), 32'd1);

    tick();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/td4_chan_mux.md
Name: td4_chan_mux

Overview:
Registered, parametrised N-channel selector: the next-generation 4:1 data selector for TD4 input/register paths. Two modes:
- Direct: transparent-select, registered.
- Scan: auto-cycles through channels with a programmable dwell.
Output is registered and carries channel tag, valid and wrap indications for downstream sequencing and display logic.

Parameters:
WIDTH, 4, bits per channel
CHANNELS, 4, number of input channels (2..16)
DWELL, 1, cycles each channel is held in scan mode (1..255)
SEL_W, derived localparam = max(1, clog2(CHANNELS)), select width; not overridable

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
data_in  in  CHANNELS*WIDTH  packed channels; channel k = data_in[k*WIDTH +: WIDTH]
sel_in  in  SEL_W  channel select (direct mode) / scan start channel (with load_sel)
mode  in  1  0 = direct, 1 = scan
load_sel  in  1  scan mode: jump scan pointer to sel_in, restart dwell
hold  in  1  freeze all state and outputs
out  out  WIDTH  registered selected data
out_sel  out  SEL_W  channel index that produced out
out_valid  out  1  out holds data from an in-range channel
wrap  out  1  one-cycle pulse when scan pointer wraps last->0

Behaviour:
- Reset (sync, active-high, highest priority, overrides hold): out=0, out_sel=0, out_valid=0, wrap=0, scan pointer=0, dwell counter=0, state=IDLE.
- States: IDLE, DIRECT, SCAN.
  - IDLE -> DIRECT when mode=0.
  - IDLE -> SCAN when mode=1.
  - DIRECT <-> SCAN follows mode each cycle; transition takes effect on the edge mode is sampled.
  - IDLE is left on the first non-reset, non-hold cycle.
- Latency: 1 cycle. Values sampled at edge n appear on out/out_sel at edge n, visible through cycle n+1.
- DIRECT: out_sel <= sel_in, out <= channel[sel_in] every cycle. Scan pointer is loaded with sel_in so a later switch to SCAN starts there. Dwell counter is cleared.
- SCAN:
  - out <= channel[ptr], out_sel <= ptr each cycle. Data is re-sampled every cycle, so out tracks input changes while dwelling.
  - Dwell counter counts 0..DWELL-1. On reaching DWELL-1: counter -> 0, ptr advances.
  - ptr = CHANNELS-1 with advance: ptr -> 0, wrap=1 for exactly that cycle; otherwise wrap=0.
  - DWELL=1: ptr advances every cycle.
- load_sel in SCAN: ptr <= sel_in, counter <= 0, no wrap pulse. out that cycle shows channel[sel_in]; load_sel has priority over dwell advance. load_sel is ignored in DIRECT.
- Out-of-range select (sel_in or ptr >= CHANNELS, only when CHANNELS not a power of 2):
  - out <= 0, out_valid <= 0, out_sel <= requested index.
  - SCAN never generates such ptr itself. If loaded via load_sel, the next advance goes to 0 with wrap=1.
  - In-range: out_valid <= 1.
- hold=1: all registers keep value, including counter, ptr and state; wrap forced 0 while held. Inputs are ignored. On release, operation resumes from the frozen counter.
- Mode change mid-dwell: SCAN->DIRECT discards the counter. DIRECT->SCAN starts at ptr = last sel_in with counter 0.
- No combinational path from inputs to outputs.

Decomposition:
- Package td4_mux_pkg:
  - state enum (IDLE, DIRECT, SCAN)
  - mode constants MODE_DIRECT=0, MODE_SCAN=1
  - function clog2_min1 for SEL_W
- Natural sub-module: td4_dwell_counter.
  - Parameter DWELL.
  - Inputs: clk, reset, en, clear.
  - Output: tick on terminal count.
  - The top owns ptr, wrap and the output registers.

Test Plan:
- Direct select, WIDTH=4, CHANNELS=4, data_in=16'hDCBA: sel_in=0,1,2,3 on successive cycles -> out=A,B,C,D one cycle later, out_sel matches, out_valid=1, wrap=0. Then data_in=16'h2345 with sel_in=0 -> out=5.
- Scan, DWELL=1, data_in=16'hDCBA, mode=1 from reset -> out sequence A,B,C,D,A,...; wrap=1 only on the cycle out returns to A (out_sel 3->0).
- Scan, DWELL=3 -> each channel shown exactly 3 cycles. hold=1 for 5 cycles mid-dwell (2nd cycle of B) -> out stays B, wrap=0. After release, B shows 1 more cycle then C.
- load_sel: in SCAN at ptr=1 assert load_sel with sel_in=3 -> next out=D, counter restarted, no wrap. Following advance -> out=A, wrap=1.
- CHANNELS=3, DIRECT, sel_in=3 -> out=0, out_valid=0, out_sel=3. sel_in=2 -> out=channel 2, out_valid=1.
- Reset mid-scan (ptr=2, counter=1), with hold=1 asserted simultaneously -> next cycle out=0, out_sel=0, out_valid=0, wrap=0. First post-reset SCAN cycle shows channel 0.
